alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter OVF_CNT_W, default 8, giving the width of the saturating overflow counter.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, a request is present.
REQ-005 SHALL have port req_ready, output, 1, the request is accepted this cycle if req_valid is high.
REQ-006 SHALL have ports req_op (input, aluop_t, operation), req_a (input, word_t, operand A) and req_b (input, word_t, operand B).
REQ-007 SHALL have port req_chain, input, 1; when high, operand A is replaced by the last captured result.
REQ-008 SHALL have port resp_valid, output, 1, a response is held.
REQ-009 SHALL have port resp_ready, input, 1, the consumer takes the response this cycle.
REQ-010 SHALL have ports resp_out (output, word_t), resp_neg, resp_over and resp_zero (outputs, 1 each), which are the captured ALU result and flags.
REQ-011 SHALL have ports alu_in1 and alu_in2 (outputs, word_t) and aluop (output, aluop_t), which drive the ALU port.
REQ-012 SHALL have ports alu_out (input, word_t) and neg_f, over_f, zero_f (inputs, 1 each), which are the combinational ALU results.
REQ-013 SHALL have port op_cnt, output, 16, completed operations; wraps.
REQ-014 SHALL have port ovf_cnt, output, OVF_CNT_W, completed operations with over_f set; saturates.

Function
REQ-015 SHALL implement FSM states IDLE (nothing in flight, no response held), EXEC (operands applied to ALU) and RESP (response held).
REQ-016 SHALL drive req_ready combinationally as (state != EXEC) && (!resp_valid || resp_ready).
REQ-017 SHALL define accept at edge N as req_valid && req_ready sampled at N.
REQ-018 SHALL, on accept, register aluop <= req_op, alu_in2 <= req_b, and alu_in1 <= (req_chain ? last_q : req_a), then enter EXEC.
REQ-019 SHALL drive alu_in1, alu_in2 and aluop only from registers, with no combinational path from req_* to the ALU.
REQ-020 SHALL hold operand registers unchanged after EXEC until the next accept.
REQ-021 SHALL, at the edge ending EXEC:
  - capture alu_out, neg_f, over_f, zero_f into the resp_* registers;
  - set last_q <= alu_out;
  - set resp_valid <= 1;
  - go to RESP.
REQ-022 SHALL give latency as: accept at edge N, EXEC during cycle N+1, resp_valid high from cycle N+2. Peak throughput is one operation per 2 cycles.
REQ-023 SHALL, in RESP with resp_ready=1 and no accept, clear resp_valid and go to IDLE.
REQ-024 SHALL, in RESP with resp_ready=1 and an accept in the same cycle, clear resp_valid and go directly to EXEC; no bubble and no response lost.
REQ-025 SHALL, in RESP with resp_ready=0, hold all resp_* outputs stable and keep req_ready=0.
REQ-026 SHALL ignore resp_ready while resp_valid=0.
REQ-027 SHALL, when req_chain=1 before any capture since reset, use last_q=0.
REQ-028 SHALL increment op_cnt by 1 at each EXEC capture, wrapping 0xFFFF to 0x0000.
REQ-029 SHALL increment ovf_cnt at each EXEC capture with over_f=1, saturating at 2^OVF_CNT_W-1.
REQ-030 SHALL leave counters and last_q unaffected by request acceptance or response drain.
REQ-031 SHALL pass flags through from the ALU unmodified; no re-computation.

Reset
REQ-032 SHALL, on RST=1 at an edge, set state to IDLE.
REQ-033 SHALL, on RST=1 at an edge, set resp_valid, resp_out, resp_neg, resp_over, resp_zero, alu_in1, alu_in2, last_q, op_cnt and ovf_cnt to 0, and aluop to ALU_SLL.
REQ-034 SHALL, on RST=1 at an edge, give req_ready=1 in the following cycle.
REQ-035 SHALL give reset priority over all other events, including accept and capture in the same cycle.
REQ-036 SHALL, on RST during EXEC or RESP, discard the in-flight or held operation with no response and no counter update.

Verification
REQ-037 SHALL verify basic ADD: accept ALU_ADD a=5 b=7 at edge N -> resp_valid=1 from N+2, resp_out=12, zero=0, neg=0, over=0, op_cnt=1.
REQ-038 SHALL verify zero flag: ALU_SUB a=3 b=3 -> resp_out=0, resp_zero=1.
REQ-039 SHALL verify chained overflow: ADD a=0x7FFFFFFF b=0, then a chained ADD with b=1 -> alu_in1=0x7FFFFFFF, resp_out=0x80000000, neg=1, over=1, ovf_cnt=1.
REQ-040 SHALL verify backpressure: resp_ready=0 for 5 cycles with req_valid=1 -> resp_* stable and req_ready=0 throughout; raising resp_ready gives drain and accept in the same cycle, and the next response appears 2 cycles later.
REQ-041 SHALL verify reset mid-operation: RST asserted during EXEC -> next cycle resp_valid=0, op_cnt unchanged at 0, aluop=ALU_SLL, req_ready=1.
REQ-042 SHALL verify counter saturation: 256 overflowing ADDs -> ovf_cnt=255 and held, op_cnt=256.

Source files
------------

// File: rtl/alu_issue.sv
// Issue stage for an external combinational ALU: accepts one request, registers operands,
// captures the ALU result one cycle later and holds it until the consumer takes it.
package alu_issue_pkg;
  localparam int unsigned WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [3:0] {
    ALU_SLL = 4'd0,
    ALU_SRL = 4'd1,
    ALU_SRA = 4'd2,
    ALU_ADD = 4'd3,
    ALU_SUB = 4'd4,
    ALU_AND = 4'd5,
    ALU_OR  = 4'd6,
    ALU_XOR = 4'd7
  } aluop_t;
endpackage

module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned OVF_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  aluop_t               req_op,
  input  word_t                req_a,
  input  word_t                req_b,
  input  logic                 req_chain,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output word_t                resp_out,
  output logic                 resp_neg,
  output logic                 resp_over,
  output logic                 resp_zero,
  output word_t                alu_in1,
  output word_t                alu_in2,
  output aluop_t               aluop,
  input  word_t                alu_out,
  input  logic                 neg_f,
  input  logic                 over_f,
  input  logic                 zero_f,
  output logic [15:0]          op_cnt,
  output logic [OVF_CNT_W-1:0] ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OVF_CNT_W-1:0] OVF_MAX = {OVF_CNT_W{1'b1}};

  state_t state;
  word_t  last_q;
  logic   accept;

  // A held response blocks new work unless it drains in the same cycle.
  assign req_ready = (state != EXEC) && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_out   <= '0;
      resp_neg   <= 1'b0;
      resp_over  <= 1'b0;
      resp_zero  <= 1'b0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      aluop      <= ALU_SLL;
      last_q     <= '0;
      op_cnt     <= '0;
      ovf_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            aluop   <= req_op;
            alu_in1 <= req_chain ? last_q : req_a;
            alu_in2 <= req_b;
            state   <= EXEC;
          end
        end
        EXEC: begin
          resp_out   <= alu_out;
          resp_neg   <= neg_f;
          resp_over  <= over_f;
          resp_zero  <= zero_f;
          resp_valid <= 1'b1;
          last_q     <= alu_out;
          op_cnt     <= op_cnt + 16'(1);
          if (over_f && (ovf_cnt != OVF_MAX)) begin
            ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
          end
          state      <= RESP;
        end
        RESP: begin
          // Drain and the next accept can share a cycle, so there is no bubble.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (accept) begin
              aluop   <= req_op;
              alu_in1 <= req_chain ? last_q : req_a;
              alu_in2 <= req_b;
              state   <= EXEC;
            end else begin
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a transaction-level reference tracks what the outputs must be each
// cycle, while directed tests pin known results, latencies and counter values.
module tb_alu_issue;
  import alu_issue_pkg::*;

  typedef struct packed {
    word_t out;
    logic  neg;
    logic  over;
    logic  zero;
  } res_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  aluop_t      req_op = ALU_SLL;
  word_t       req_a = '0;
  word_t       req_b = '0;
  logic        req_chain = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  word_t       resp_out;
  logic        resp_neg, resp_over, resp_zero;
  word_t       alu_in1, alu_in2;
  aluop_t      aluop;
  word_t       alu_out;
  logic        neg_f, over_f, zero_f;
  logic [15:0] op_cnt;
  logic [7:0]  ovf_cnt;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  alu_issue #(.OVF_CNT_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_chain(req_chain),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_out(resp_out), .resp_neg(resp_neg), .resp_over(resp_over), .resp_zero(resp_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .aluop(aluop),
    .alu_out(alu_out), .neg_f(neg_f), .over_f(over_f), .zero_f(zero_f),
    .op_cnt(op_cnt), .ovf_cnt(ovf_cnt)
  );

  function automatic res_t alu_ref(aluop_t op, word_t a, word_t b);
    res_t r;
    r.over = 1'b0;
    case (op)
      ALU_SLL: r.out = a << b[4:0];
      ALU_SRL: r.out = a >> b[4:0];
      ALU_SRA: r.out = word_t'($signed(a) >>> b[4:0]);
      ALU_ADD: begin
        r.out  = a + b;
        r.over = (a[31] == b[31]) && (r.out[31] != a[31]);
      end
      ALU_SUB: begin
        r.out  = a - b;
        r.over = (a[31] != b[31]) && (r.out[31] != a[31]);
      end
      ALU_AND: r.out = a & b;
      ALU_OR:  r.out = a | b;
      ALU_XOR: r.out = a ^ b;
      default: r.out = '0;
    endcase
    r.neg  = r.out[31];
    r.zero = (r.out == '0);
    return r;
  endfunction

  // Environment ALU driven by the DUT's operand registers.
  res_t alu_res;
  always_comb alu_res = alu_ref(aluop, alu_in1, alu_in2);
  assign alu_out = alu_res.out;
  assign neg_f   = alu_res.neg;
  assign over_f  = alu_res.over;
  assign zero_f  = alu_res.zero;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: one op may be in the ALU, one response may be held.
  logic   m_exec = 1'b0;
  logic   m_valid = 1'b0;
  res_t   m_pend = '0;
  res_t   m_resp = '0;
  word_t  m_last = '0;
  int     m_ops = 0;
  int     m_ovf = 0;
  word_t  m_in1 = '0;
  word_t  m_in2 = '0;
  aluop_t m_op = ALU_SLL;
  logic   m_ready, m_acc;
  word_t  m_a;

  // Compare against the reference, then advance it with the inputs the next edge samples.
  always @(negedge CLK) begin
    m_ready = !m_exec && (!m_valid || resp_ready);
    check("req_ready", 32'(req_ready), 32'(m_ready));
    check("resp_valid", 32'(resp_valid), 32'(m_valid));
    if (m_valid) begin
      check("resp_out", resp_out, m_resp.out);
      check("resp_flags", 32'({resp_neg, resp_over, resp_zero}),
            32'({m_resp.neg, m_resp.over, m_resp.zero}));
    end
    check("op_cnt", 32'(op_cnt), 32'(m_ops));
    check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    check("alu_in1", alu_in1, m_in1);
    check("alu_in2", alu_in2, m_in2);
    check("aluop", 32'(aluop), 32'(m_op));

    if (RST) begin
      m_exec = 1'b0; m_valid = 1'b0; m_last = '0; m_ops = 0; m_ovf = 0;
      m_in1 = '0; m_in2 = '0; m_op = ALU_SLL;
    end else begin
      m_acc = req_valid && m_ready;
      m_a   = req_chain ? m_last : req_a;
      if (m_valid && resp_ready) m_valid = 1'b0;
      if (m_exec) begin
        m_resp  = m_pend;
        m_valid = 1'b1;
        m_last  = m_pend.out;
        m_ops   = (m_ops + 1) % 65536;
        if (m_pend.over && m_ovf < 255) m_ovf++;
        m_exec  = 1'b0;
      end
      if (m_acc) begin
        m_in1  = m_a;
        m_in2  = req_b;
        m_op   = req_op;
        m_pend = alu_ref(req_op, m_a, req_b);
        m_exec = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present a request and hold it until accepted; returns just after the accept edge.
  task automatic send(aluop_t op, word_t a, word_t b, logic chain);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_chain = chain;
    forever begin
      @(negedge CLK);
      if (req_ready) break;
      n++;
      if (n > 50) begin
        checks++; failures++;
        $display("FAIL send_timeout: req_ready never rose, got 0 expected 1");
        break;
      end
    end
    step();
    req_valid = 1'b0; req_chain = 1'b0;
  endtask

  // Counts falling edges until resp_valid is seen; leaves time at that falling edge.
  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!resp_valid && lat < 50);
    if (!resp_valid) begin
      checks++; failures++;
      $display("FAIL resp_timeout: resp_valid got 0 expected 1");
    end
  endtask

  typedef struct {
    aluop_t op;
    word_t  a;
    word_t  b;
    word_t  out;
    logic   over;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    vecs[0] = '{ALU_SLL, 32'h1,        32'd4,     32'h10,       1'b0};
    vecs[1] = '{ALU_SRL, 32'h80000000, 32'd31,    32'h1,        1'b0};
    vecs[2] = '{ALU_SRA, 32'h80000000, 32'd4,     32'hF8000000, 1'b0};
    vecs[3] = '{ALU_AND, 32'hF0F0,     32'hFF00,  32'hF000,     1'b0};
    vecs[4] = '{ALU_OR,  32'hF0F0,     32'hFF00,  32'hFFF0,     1'b0};
    vecs[5] = '{ALU_XOR, 32'hF0F0,     32'hFF00,  32'h0FF0,     1'b0};
    vecs[6] = '{ALU_SUB, 32'h0,        32'h1,     32'hFFFFFFFF, 1'b0};
    vecs[7] = '{ALU_SUB, 32'h80000000, 32'h1,     32'h7FFFFFFF, 1'b1};

    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_aluop", 32'(aluop), 32'(ALU_SLL));
    check("rst_op_cnt", 32'(op_cnt), 32'd0);
    step();

    // Basic add with latency measured from the accept edge.
    send(ALU_ADD, 32'd5, 32'd7, 1'b0);
    wait_resp(lat);
    check("add_latency", 32'(lat), 32'd2);
    check("add_out", resp_out, 32'd12);
    check("add_flags", 32'({resp_neg, resp_over, resp_zero}), 32'd0);
    check("add_op_cnt", 32'(op_cnt), 32'd1);
    step();

    send(ALU_SUB, 32'd3, 32'd3, 1'b0);
    wait_resp(lat);
    check("sub_out", resp_out, 32'd0);
    check("sub_zero", 32'(resp_zero), 32'd1);
    step();

    // Chained add overflowing into the sign bit.
    send(ALU_ADD, 32'h7FFFFFFF, 32'd0, 1'b0);
    wait_resp(lat);
    step();
    send(ALU_ADD, 32'h00001234, 32'd1, 1'b1);
    @(negedge CLK);
    check("chain_in1", alu_in1, 32'h7FFFFFFF);
    wait_resp(lat);
    check("chain_out", resp_out, 32'h80000000);
    check("chain_neg_over", 32'({resp_neg, resp_over}), 32'd3);
    check("chain_ovf_cnt", 32'(ovf_cnt), 32'd1);
    step();

    // Backpressure with a waiting request, then drain and accept together.
    resp_ready = 1'b0;
    send(ALU_ADD, 32'd1, 32'd2, 1'b0);
    wait_resp(lat);
    check("bp_out", resp_out, 32'd3);
    step();
    req_valid = 1'b1; req_op = ALU_SUB; req_a = 32'd10; req_b = 32'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_hold_valid", 32'(resp_valid), 32'd1);
      check("bp_hold_out", resp_out, 32'd3);
    end
    step();
    resp_ready = 1'b1;
    @(negedge CLK);
    check("bp_release_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    @(negedge CLK);
    check("bp_exec_valid", 32'(resp_valid), 32'd0);
    @(negedge CLK);
    check("bp_next_valid", 32'(resp_valid), 32'd1);
    check("bp_next_out", resp_out, 32'd6);
    step();

    // Assorted operations against hand-computed results.
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      wait_resp(lat);
      check("vec_out", resp_out, vecs[i].out);
      check("vec_over", 32'(resp_over), 32'(vecs[i].over));
      step();
    end

    // Reset while the operation is in EXEC.
    send(ALU_ADD, 32'd9, 32'd9, 1'b0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    @(negedge CLK);
    check("rstx_resp_valid", 32'(resp_valid), 32'd0);
    check("rstx_op_cnt", 32'(op_cnt), 32'd0);
    check("rstx_aluop", 32'(aluop), 32'(ALU_SLL));
    check("rstx_req_ready", 32'(req_ready), 32'd1);
    step();

    // Overflow counter saturation.
    for (int i = 0; i < 256; i++) begin
      send(ALU_ADD, 32'h7FFFFFFF, 32'd1, 1'b0);
      wait_resp(lat);
      if (i == 254) check("sat_ovf_255", 32'(ovf_cnt), 32'd255);
      if (i == 255) begin
        check("sat_ovf_held", 32'(ovf_cnt), 32'd255);
        check("sat_op_cnt", 32'(op_cnt), 32'd256);
      end
      step();
    end

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
